// File: rtl/fifo_burst_pkg.sv
// Shared types and defaults for the FIFO burst reader and its synchronizer.
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 7;
  localparam int DEF_THRESH = 64;
  localparam int DEF_RD_LAT = 1;
  localparam int ERR_CNT_W  = 16;

endpackage

// File: rtl/fifo_burst_reader_sync_2ff.sv
// Generic single-bit two-flop synchronizer into the sys_clk domain.
module sync_2ff (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic d,
  output logic q
);

  logic stage1_reg;
  logic stage2_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stage1_reg <= 1'b0;
      stage2_reg <= 1'b0;
    end else begin
      stage1_reg <= d;
      stage2_reg <= stage1_reg;
    end
  end

  assign q = stage2_reg;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller: waits for full/threshold, drains the FIFO, streams words out.
// Optional sequence checker enabled with `define FIFO_BURST_READER_SEQ_CHECK_EN.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int THRESH = DEF_THRESH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  input  logic [CNT_W-1:0]     fifo_rd_data_count,
  input  logic [DATA_W-1:0]    fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 burst_done,
  output logic [CNT_W:0]       burst_len,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [CNT_W:0]   CNT_MAX  = '1;

  logic                full_s2;
  state_t              state_reg, state_next;
  logic                rd_en;
  logic [RD_LAT-1:0]   vld_pipe_reg, vld_pipe_next;
  logic                pipe_idle;
  logic                word_take;
  logic [CNT_W:0]      word_cnt_reg;
  logic [DATA_W-1:0]   out_data_reg;
  logic                out_valid_reg;
  logic                burst_done_reg;
  logic [CNT_W:0]      burst_len_reg;

  sync_2ff u_full_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .d       (fifo_full),
    .q       (full_s2)
  );

  // Valid pipe tracks each issued read until its data appears on fifo_rd_data.
  assign vld_pipe_next[0] = fifo_rd_en;
  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_vld_pipe
      assign vld_pipe_next[gi] = vld_pipe_reg[gi-1];
    end
  endgenerate

  assign pipe_idle = (vld_pipe_reg == '0);
  assign word_take = vld_pipe_reg[RD_LAT-1];

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (full_s2 || (fifo_rd_data_count >= THRESH_C)) state_next = READ;
      end
      READ: begin
        if (fifo_empty) state_next = DRAIN;
        else            rd_en      = 1'b1;
      end
      DRAIN: begin
        if (pipe_idle) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (sys_rst) rd_en = 1'b0;
  end

  assign fifo_rd_en = rd_en;
  assign busy       = (state_reg == READ) || (state_reg == DRAIN);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg      <= IDLE;
      vld_pipe_reg   <= '0;
      word_cnt_reg   <= '0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      burst_done_reg <= 1'b0;
      burst_len_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      vld_pipe_reg   <= vld_pipe_next;
      out_valid_reg  <= word_take;
      burst_done_reg <= 1'b0;
      if (word_take) out_data_reg <= fifo_rd_data;
      if (fifo_rd_en && (word_cnt_reg != CNT_MAX))
        word_cnt_reg <= word_cnt_reg + (CNT_W+1)'(1);
      // Burst closes only once every issued read has been delivered.
      if ((state_reg == DRAIN) && pipe_idle) begin
        burst_len_reg  <= word_cnt_reg;
        burst_done_reg <= 1'b1;
        word_cnt_reg   <= '0;
      end
    end
  end

  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;
  assign burst_done = burst_done_reg;
  assign burst_len  = burst_len_reg;

`ifdef FIFO_BURST_READER_SEQ_CHECK_EN
  logic [DATA_W-1:0]    ref_reg;
  logic                 ref_ok_reg;
  logic                 seq_err_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;
  logic [DATA_W-1:0]    ref_inc;
  logic                 mismatch;

  assign ref_inc  = ref_reg + DATA_W'(1);
  assign mismatch = ref_ok_reg && (fifo_rd_data != ref_inc);

  // Reference survives across bursts; a mismatch resyncs it to the received word.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ref_reg     <= '0;
      ref_ok_reg  <= 1'b0;
      seq_err_reg <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      seq_err_reg <= 1'b0;
      if (word_take) begin
        ref_reg    <= fifo_rd_data;
        ref_ok_reg <= 1'b1;
        if (mismatch) begin
          seq_err_reg <= 1'b1;
          if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
        end
      end
    end
  end

  assign seq_err = seq_err_reg;
  assign err_cnt = err_cnt_reg;
`else
  assign seq_err = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench: behavioural FIFO + stream/burst scoreboard around fifo_burst_reader.
module tb_fifo_burst_reader;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 7;
  localparam int THRESH = 64;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 128;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int LMAX   = (1 << (CNT_W + 1)) - 1;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              fifo_full = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [CNT_W-1:0]  fifo_rd_data_count = '0;
  logic [DATA_W-1:0] fifo_rd_data = '0;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              busy;
  logic              burst_done;
  logic [CNT_W:0]    burst_len;
  logic              seq_err;
  logic [15:0]       err_cnt;

  always #5 sys_clk = ~sys_clk;

  fifo_burst_reader #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .THRESH(THRESH), .RD_LAT(RD_LAT)
  ) dut (
    .sys_clk            (sys_clk),
    .sys_rst            (sys_rst),
    .fifo_full          (fifo_full),
    .fifo_empty         (fifo_empty),
    .fifo_rd_data_count (fifo_rd_data_count),
    .fifo_rd_data       (fifo_rd_data),
    .fifo_rd_en         (fifo_rd_en),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .busy               (busy),
    .burst_done         (burst_done),
    .burst_len          (burst_len),
    .seq_err            (seq_err),
    .err_cnt            (err_cnt)
  );

  typedef struct {
    logic [7:0] d;
    int         due;
  } sb_t;

  logic [7:0] fq[$];
  logic [7:0] stage[$];
  sb_t        sb[$];
  logic [7:0] dpipe [RD_LAT];

  int         edge_n = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic       rd_pending = 1'b0;
  logic [7:0] last_out = '0;
  int         pops_since = 0;
  logic       ended = 1'b0;
  int         nbursts = 0;
  int         delivered = 0;
  int         pushed = 0;
  logic       ref_ok = 1'b0;
  logic [7:0] ref_w = '0;
  int         exp_err_cnt = 0;
  logic       full_force = 1'b0;
  logic [7:0] next_word = '0;

  always @(posedge sys_clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_n);
  endtask

  // One clock cycle: account for the edge just passed, check outputs, then drive the FIFO side.
  task automatic tick(input int npush, input logic rst, input bit rnd);
    logic       prev_rst;
    logic [7:0] w;
    logic       exp_err;
    sb_t        e;
    @(negedge sys_clk);
    prev_rst = sys_rst;
    exp_err  = 1'b0;
    for (int i = RD_LAT - 1; i > 0; i--) dpipe[i] = dpipe[i-1];
    dpipe[0] = 8'($urandom);
    if (rd_pending && fq.size() > 0) begin
      w = fq.pop_front();
      dpipe[0] = w;
      sb.push_back('{w, edge_n + RD_LAT});
      if (pops_since < LMAX) pops_since++;
    end
    if (prev_rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_burst_done", burst_done, 0);
      check("rst_burst_len", burst_len, 0);
      check("rst_busy", busy, 0);
      check("rst_seq_err", seq_err, 0);
      check("rst_err_cnt", err_cnt, 0);
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) check("spurious_valid", out_valid, 0);
        else begin
          e = sb.pop_front();
          check("out_data", out_data, e.d);
          check("out_latency", edge_n, e.due);
          exp_err = ref_ok && (e.d != 8'(ref_w + 8'd1));
          if (exp_err && exp_err_cnt < 65535) exp_err_cnt++;
          ref_w = e.d;
          ref_ok = 1'b1;
          last_out = e.d;
          delivered++;
        end
      end else begin
        check("out_hold", out_data, last_out);
        if (sb.size() > 0 && sb[0].due <= edge_n) begin
          check("missing_valid", out_valid, 1);
          void'(sb.pop_front());
        end
      end
`ifdef FIFO_BURST_READER_SEQ_CHECK_EN
      check("seq_err", seq_err, exp_err);
      check("err_cnt", err_cnt, exp_err_cnt);
`else
      check("seq_err_off", seq_err, 0);
      check("err_cnt_off", err_cnt, 0);
`endif
      if (burst_done) begin
        check("burst_len", burst_len, pops_since);
        check("done_after_drain", sb.size(), 0);
        $display("burst done at edge %0d: len %0d", edge_n, burst_len);
        if (pops_since > 0) nbursts++;
        pops_since = 0;
        ended = 1'b0;
      end
    end

    sys_rst = rst;
    if (rst) begin
      sb.delete();
      pops_since = 0;
      ended = 1'b0;
      ref_ok = 1'b0;
      exp_err_cnt = 0;
      last_out = '0;
    end
    for (int i = 0; i < npush; i++) begin
      if (fq.size() < DEPTH) begin
        if (stage.size() > 0) w = stage.pop_front();
        else if (rnd)         w = 8'($urandom);
        else                  w = next_word;
        fq.push_back(w);
        next_word = w + 8'd1;
        pushed++;
      end
    end
    fifo_empty         = (fq.size() == 0);
    fifo_rd_data_count = (fq.size() > CMAX) ? CNT_W'(CMAX) : CNT_W'(fq.size());
    fifo_full          = full_force || (fq.size() >= DEPTH);
    fifo_rd_data       = dpipe[RD_LAT-1];
    if (pops_since > 0 && fq.size() == 0 && !rst) ended = 1'b1;
    #1;
    rd_pending = fifo_rd_en;
    if (fq.size() == 0) check("rd_when_empty", rd_pending, 0);
    if (rst)            check("rd_in_reset", rd_pending, 0);
    if (ended)          check("rd_after_empty", rd_pending, 0);
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int c = 0; c < 3000 && quiet < 8; c++) begin
      tick(0, 1'b0, 1'b0);
      if (fq.size() == 0 && sb.size() == 0 && !busy && pops_since == 0) quiet++;
      else quiet = 0;
    end
    check("idle_reached", quiet >= 8, 1);
  endtask

  initial begin
    int b0, d0, p0;
    for (int i = 0; i < RD_LAT; i++) dpipe[i] = '0;

    // Reset held with full asserted and nothing to read
    full_force = 1'b1;
    repeat (3) tick(0, 1'b1, 1'b0);
    tick(0, 1'b0, 1'b0);
    tick(0, 1'b0, 1'b0); check("busy_sync0", busy, 0);
    tick(0, 1'b0, 1'b0); check("busy_sync1", busy, 0);
    tick(0, 1'b0, 1'b0); check("busy_sync2", busy, 1);
    full_force = 1'b0;
    wait_idle();
    check("empty_bursts_only", nbursts, 0);

    // Full burst of 0..127
    b0 = nbursts; d0 = delivered;
    next_word = '0;
    tick(DEPTH, 1'b0, 1'b0);
    wait_idle();
    check("full_bursts", nbursts - b0, 1);
    check("full_len", burst_len, DEPTH);
    check("full_words", delivered - d0, DEPTH);

    // Threshold ramp, one word per cycle
    b0 = nbursts;
    for (int i = 0; i < THRESH; i++) begin
      tick(1, 1'b0, 1'b1);
      check("thr_no_early", rd_pending, 0);
    end
    tick(0, 1'b0, 1'b0);
    check("thr_start", rd_pending, 1);
    wait_idle();
    check("thr_bursts", nbursts - b0, 1);
    check("thr_len", burst_len, THRESH);

    // Slow writer: empty bubbles end bursts early
    d0 = delivered; p0 = pushed;
    tick(THRESH, 1'b0, 1'b0);
    for (int i = 0; i < 250; i++)
      tick(($urandom_range(0, 1) == 0) ? 1 : 0, 1'b0, $urandom_range(0, 15) == 0);
    tick(THRESH, 1'b0, 1'b0);
    wait_idle();
    check("bubble_all_words", delivered - d0, pushed - p0);

    // Reset in the middle of a burst
    b0 = nbursts;
    tick(100, 1'b0, 1'b0);
    for (int c = 0; c < 300 && pops_since < 20; c++) tick(0, 1'b0, 1'b0);
    check("pre_reset_pops", pops_since, 20);
    tick(0, 1'b1, 1'b0);
    tick(0, 1'b0, 1'b0);
    check("post_rst_len", burst_len, 0);
    check("post_rst_valid", out_valid, 0);
    wait_idle();
    check("post_rst_bursts", nbursts - b0, 1);

    // Sequence stream with wrap and one gap
    for (int v = 250; v < 256; v++) stage.push_back(8'(v));
    for (int v = 0; v <= 10; v++) stage.push_back(8'(v));
    for (int v = 12; stage.size() < THRESH; v++) stage.push_back(8'(v));
    d0 = delivered;
    tick(THRESH, 1'b0, 1'b0);
    wait_idle();
    check("seq_words", delivered - d0, THRESH);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
